// File: rtl/acc_cpu_pkg.sv
// ---------------------------------------------------------------------------
// acc_cpu_pkg
// Shared definitions for the multicycle accumulator processor: default word
// and address widths, the wait-counter width, the instruction opcode values
// and the memory responder state encoding.
// No ports (package).
// ---------------------------------------------------------------------------
package acc_cpu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 5;

  // Wait-state counter width; WAIT_STATES is legal in 0..15.
  localparam int WAIT_CNT_W = 4;

  // Instruction word = {opcode[2:0], address[4:0]}.
  localparam logic [2:0] OP_LDA = 3'd0;
  localparam logic [2:0] OP_STA = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SUB = 3'd3;
  localparam logic [2:0] OP_JMP = 3'd4;
  localparam logic [2:0] OP_JZ  = 3'd5;
  localparam logic [2:0] OP_NOP = 3'd6;
  localparam logic [2:0] OP_HLT = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_state_t;

endpackage

// File: rtl/acc_word_ram.sv
// ---------------------------------------------------------------------------
// acc_word_ram
// Single-port word array with synchronous write and registered read. The
// array itself is never reset so program contents survive a reset; only the
// read register is cleared.
// Ports:
//   i_clk    rising-edge clock
//   i_rst    async active-high reset (read register only)
//   i_we     write strobe
//   i_re     read strobe; o_rdata updates only when asserted
//   i_addr   word address
//   i_wdata  write data
//   o_rdata  registered read data, held between reads
// ---------------------------------------------------------------------------
module acc_word_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 5
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_we,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  always_ff @(posedge i_clk) begin
    if (i_we) r_mem[i_addr] <= i_wdata;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst)     r_rdata <= '0;
    else if (i_re) r_rdata <= r_mem[i_addr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/acc_memory_responder.sv
// ---------------------------------------------------------------------------
// acc_memory_responder
// Memory-side responder for the accumulator processor. Captures a processor
// read/write request in IDLE, waits WAIT_STATES cycles, then completes in a
// one-cycle DONE state that pulses o_memReady. A back-door loader may write
// words while the responder is idle and takes priority over the processor.
// Ports:
//   i_clk, i_rst            clock, async active-high reset
//   i_memRead, i_memWrite   processor requests
//   i_addr, i_writeData     processor address / write data
//   o_readData              registered read result, held between reads
//   o_memReady              one-cycle completion pulse
//   o_protocol_err          one-cycle pulse: read and write both requested
//   i_load_en/addr/data     back-door write request
//   o_load_ack              one-cycle pulse: back-door word written
// ---------------------------------------------------------------------------
module acc_memory_responder
  import acc_cpu_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int ADDR_W      = ADDR_W_DEF,
  parameter int WAIT_STATES = 2
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_memRead,
  input  logic              i_memWrite,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_writeData,
  output logic [DATA_W-1:0] o_readData,
  output logic              o_memReady,
  output logic              o_protocol_err,
  input  logic              i_load_en,
  input  logic [ADDR_W-1:0] i_load_addr,
  input  logic [DATA_W-1:0] i_load_data,
  output logic              o_load_ack
);

  mem_state_t              r_state;
  mem_state_t              w_nextState;
  logic [WAIT_CNT_W-1:0]   r_waitCnt;
  logic [ADDR_W-1:0]       r_capAddr;
  logic [DATA_W-1:0]       r_capData;
  logic                    r_capWrite;
  logic                    r_protoErr;
  logic                    r_loadAck;

  logic                    w_req;
  logic                    w_doLoad;
  logic                    w_capture;
  logic                    w_enterDone;
  logic                    w_accWrite;
  logic [ADDR_W-1:0]       w_accAddr;
  logic [DATA_W-1:0]       w_accData;
  logic                    w_ramWe;
  logic                    w_ramRe;
  logic [ADDR_W-1:0]       w_ramAddr;
  logic [DATA_W-1:0]       w_ramWdata;

  assign w_req = i_memRead | i_memWrite;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= IDLE;
    else       r_state <= w_nextState;
  end

  always_comb begin
    w_nextState = r_state;
    case (r_state)
      IDLE: if (!i_load_en && w_req) w_nextState = (WAIT_STATES == 0) ? DONE : WAIT;
      WAIT: if (r_waitCnt == WAIT_CNT_W'(1)) w_nextState = DONE;
      DONE: w_nextState = IDLE;
      default: w_nextState = IDLE;
    endcase
  end

  // The array is touched on the edge that enters DONE, so the access source
  // is the live inputs when that edge is also the capture edge (no wait
  // states) and the captured registers otherwise. Both-bits requests act as
  // writes because i_memWrite alone selects the operation.
  always_comb begin
    w_doLoad    = 1'b0;
    w_capture   = 1'b0;
    w_enterDone = 1'b0;
    w_accWrite  = r_capWrite;
    w_accAddr   = r_capAddr;
    w_accData   = r_capData;
    case (r_state)
      IDLE: begin
        w_doLoad    = i_load_en;
        w_capture   = !i_load_en && w_req;
        w_accWrite  = i_memWrite;
        w_accAddr   = i_addr;
        w_accData   = i_writeData;
        w_enterDone = w_capture && (WAIT_STATES == 0);
      end
      WAIT:    w_enterDone = (r_waitCnt == WAIT_CNT_W'(1));
      default: ;
    endcase
    w_ramWe    = w_doLoad | (w_enterDone & w_accWrite);
    w_ramRe    = w_enterDone & ~w_accWrite;
    w_ramAddr  = w_doLoad ? i_load_addr : w_accAddr;
    w_ramWdata = w_doLoad ? i_load_data : w_accData;
  end

  // Request capture and wait counter; the counter is only meaningful in WAIT.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_waitCnt  <= '0;
      r_capAddr  <= '0;
      r_capData  <= '0;
      r_capWrite <= 1'b0;
    end else if (w_capture) begin
      r_waitCnt  <= WAIT_CNT_W'(WAIT_STATES);
      r_capAddr  <= i_addr;
      r_capData  <= i_writeData;
      r_capWrite <= i_memWrite;
    end else if (r_state == WAIT && r_waitCnt != '0) begin
      r_waitCnt  <= r_waitCnt - WAIT_CNT_W'(1);
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_protoErr <= 1'b0;
      r_loadAck  <= 1'b0;
    end else begin
      r_protoErr <= w_capture & i_memRead & i_memWrite;
      r_loadAck  <= w_doLoad;
    end
  end

  acc_word_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_we    (w_ramWe),
    .i_re    (w_ramRe),
    .i_addr  (w_ramAddr),
    .i_wdata (w_ramWdata),
    .o_rdata (o_readData)
  );

  assign o_memReady     = (r_state == DONE);
  assign o_protocol_err = r_protoErr;
  assign o_load_ack     = r_loadAck;

endmodule

// File: tb/tb_acc_memory_responder.sv
// ---------------------------------------------------------------------------
// tb_acc_memory_responder
// Three responders (WAIT_STATES = 2, 0, 3) share one input stream. A
// transaction-level model per instance predicts every output each cycle:
// an access captured at edge c completes at edge c+WS and the responder
// accepts the next request or load from edge c+WS+2 onward.
// ---------------------------------------------------------------------------
module tb_acc_memory_responder;

  localparam int WS_A = 2;
  localparam int WS_B = 0;
  localparam int WS_C = 3;
  localparam int NI   = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       memRead, memWrite, loadEn;
  logic [4:0] addr, loadAddr;
  logic [7:0] writeData, loadData;

  logic [7:0] readData [NI];
  logic       memReady [NI];
  logic       protoErr [NI];
  logic       loadAck  [NI];

  int nChecks = 0;
  int nErrors = 0;

  int         wsOf     [NI];
  logic [7:0] mdlMem   [NI][32];
  int         doneAt   [NI];
  int         nextFree [NI];
  logic [4:0] pAddr    [NI];
  logic [7:0] pData    [NI];
  logic       pWrite   [NI];
  logic       expReady [NI];
  logic       expErr   [NI];
  logic       expAck   [NI];
  logic [7:0] expRd    [NI];
  int         cyc = 0;

  always #5 clk = ~clk;

  acc_memory_responder #(.DATA_W(8), .ADDR_W(5), .WAIT_STATES(WS_A)) u_dutA (
    .i_clk(clk), .i_rst(rst), .i_memRead(memRead), .i_memWrite(memWrite),
    .i_addr(addr), .i_writeData(writeData), .o_readData(readData[0]),
    .o_memReady(memReady[0]), .o_protocol_err(protoErr[0]),
    .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_data(loadData),
    .o_load_ack(loadAck[0]));

  acc_memory_responder #(.DATA_W(8), .ADDR_W(5), .WAIT_STATES(WS_B)) u_dutB (
    .i_clk(clk), .i_rst(rst), .i_memRead(memRead), .i_memWrite(memWrite),
    .i_addr(addr), .i_writeData(writeData), .o_readData(readData[1]),
    .o_memReady(memReady[1]), .o_protocol_err(protoErr[1]),
    .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_data(loadData),
    .o_load_ack(loadAck[1]));

  acc_memory_responder #(.DATA_W(8), .ADDR_W(5), .WAIT_STATES(WS_C)) u_dutC (
    .i_clk(clk), .i_rst(rst), .i_memRead(memRead), .i_memWrite(memWrite),
    .i_addr(addr), .i_writeData(writeData), .o_readData(readData[2]),
    .o_memReady(memReady[2]), .o_protocol_err(protoErr[2]),
    .i_load_en(loadEn), .i_load_addr(loadAddr), .i_load_data(loadData),
    .o_load_ack(loadAck[2]));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    nChecks++;
    if (got !== want) begin
      nErrors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
    end
  endtask

  task automatic modelReset();
    for (int k = 0; k < NI; k++) begin
      doneAt[k]   = -1;
      nextFree[k] = 0;
      expReady[k] = 1'b0;
      expErr[k]   = 1'b0;
      expAck[k]   = 1'b0;
      expRd[k]    = 8'h00;
    end
  endtask

  // One clock edge of the reference: first decide whether the responder is
  // free to accept a load or request, then retire an access due this edge.
  task automatic modelEdge();
    for (int k = 0; k < NI; k++) begin
      expReady[k] = 1'b0;
      expErr[k]   = 1'b0;
      expAck[k]   = 1'b0;
      if (!rst) begin
        if (cyc >= nextFree[k]) begin
          if (loadEn) begin
            mdlMem[k][loadAddr] = loadData;
            expAck[k] = 1'b1;
          end else if (memRead || memWrite) begin
            pAddr[k]    = addr;
            pData[k]    = writeData;
            pWrite[k]   = memWrite;
            doneAt[k]   = cyc + wsOf[k];
            nextFree[k] = cyc + wsOf[k] + 2;
            expErr[k]   = memRead & memWrite;
          end
        end
        if (doneAt[k] == cyc) begin
          expReady[k] = 1'b1;
          if (pWrite[k]) mdlMem[k][pAddr[k]] = pData[k];
          else           expRd[k] = mdlMem[k][pAddr[k]];
          doneAt[k] = -1;
        end
      end
    end
    cyc++;
  endtask

  task automatic compareAll();
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("memReady[%0d]", k), 32'(memReady[k]), 32'(expReady[k]));
      checkOutput($sformatf("protoErr[%0d]", k), 32'(protoErr[k]), 32'(expErr[k]));
      checkOutput($sformatf("loadAck[%0d]", k),  32'(loadAck[k]),  32'(expAck[k]));
      checkOutput($sformatf("readData[%0d]", k), 32'(readData[k]), 32'(expRd[k]));
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelEdge();
    @(negedge clk);
    compareAll();
  endtask

  task automatic applyStimulus(input logic rd, input logic wr, input logic [4:0] a,
                               input logic [7:0] wd, input logic le,
                               input logic [4:0] la, input logic [7:0] ld);
    memRead   = rd;
    memWrite  = wr;
    addr      = a;
    writeData = wd;
    loadEn    = le;
    loadAddr  = la;
    loadData  = ld;
    stepCycle();
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b0, 5'd0, 8'h00);
  endtask

  // Asserts reset between edges, checks the outputs clear at once, holds it
  // over one edge and releases it on the following falling edge.
  task automatic doReset();
    memRead = 1'b0; memWrite = 1'b0; loadEn = 1'b0;
    rst = 1'b1;
    #1;
    modelReset();
    for (int k = 0; k < NI; k++) begin
      checkOutput($sformatf("rstReady[%0d]", k), 32'(memReady[k]), 32'd0);
      checkOutput($sformatf("rstData[%0d]", k),  32'(readData[k]), 32'd0);
    end
    stepCycle();
    rst = 1'b0;
  endtask

  initial begin
    wsOf = '{WS_A, WS_B, WS_C};
    rst = 1'b1;
    memRead = 1'b0; memWrite = 1'b0; loadEn = 1'b0;
    addr = '0; writeData = '0; loadAddr = '0; loadData = '0;
    @(negedge clk);
    doReset();

    // Give every word a defined value through the back door.
    for (int a = 0; a < 32; a++)
      applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'(a), 8'($urandom));

    // Load then read.
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd3, 8'h5A);
    idleCycles(1);
    applyStimulus(1'b1, 1'b0, 5'd3, 8'h00, 1'b0, 5'd0, 8'h00);
    idleCycles(6);
    checkOutput("loadRead", 32'(readData[0]), 32'h5A);

    // Write then read back; the write leaves readData alone.
    applyStimulus(1'b0, 1'b1, 5'd7, 8'hC3, 1'b0, 5'd0, 8'h00);
    idleCycles(6);
    checkOutput("writeHold", 32'(readData[0]), 32'h5A);
    applyStimulus(1'b1, 1'b0, 5'd7, 8'h00, 1'b0, 5'd0, 8'h00);
    idleCycles(6);
    checkOutput("readBack", 32'(readData[2]), 32'hC3);

    // Load and read together: load wins, read is taken on the next edge.
    applyStimulus(1'b1, 1'b0, 5'd6, 8'h00, 1'b1, 5'd6, 8'h77);
    checkOutput("simAck", 32'(loadAck[1]), 32'd1);
    checkOutput("simReady", 32'(memReady[1]), 32'd0);
    applyStimulus(1'b1, 1'b0, 5'd6, 8'h00, 1'b0, 5'd0, 8'h00);
    idleCycles(6);
    checkOutput("simRead", 32'(readData[0]), 32'h77);

    // Read and write together behave as a write plus an error pulse.
    applyStimulus(1'b1, 1'b1, 5'd2, 8'h11, 1'b0, 5'd0, 8'h00);
    checkOutput("protoPulse", 32'(protoErr[0]), 32'd1);
    idleCycles(6);
    applyStimulus(1'b1, 1'b0, 5'd2, 8'h00, 1'b0, 5'd0, 8'h00);
    idleCycles(6);
    checkOutput("protoWrite", 32'(readData[0]), 32'h11);

    // Reset during a pending write aborts it (the zero-wait build has
    // already committed it on the capture edge).
    applyStimulus(1'b0, 1'b0, 5'd0, 8'h00, 1'b1, 5'd9, 8'h44);
    idleCycles(2);
    applyStimulus(1'b0, 1'b1, 5'd9, 8'hEE, 1'b0, 5'd0, 8'h00);
    doReset();
    idleCycles(4);
    applyStimulus(1'b1, 1'b0, 5'd9, 8'h00, 1'b0, 5'd0, 8'h00);
    idleCycles(6);
    checkOutput("abortA", 32'(readData[0]), 32'h44);
    checkOutput("abortC", 32'(readData[2]), 32'h44);
    checkOutput("abortB", 32'(readData[1]), 32'hEE);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 199) == 0) doReset();
      else applyStimulus(($urandom_range(0, 2) == 0), ($urandom_range(0, 3) == 0),
                         5'($urandom), 8'($urandom), ($urandom_range(0, 5) == 0),
                         5'($urandom), 8'($urandom));
    end
    idleCycles(6);

    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule
